// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with a one-entry skid register and branch redirect.
// Stale responses to a request issued before a taken branch are dropped in DISCARD.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch_in,
    input  logic        zero_in,
    input  logic [31:0] branch_imm,
    input  logic [31:0] branch_pc4,
    input  logic        stall_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic        valid_out
);
    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

    state_t      state_q;
    logic        req_q, valid_q;
    logic [31:0] addr_q, instr_q, pc_q, pc4_q, skid_instr_q, skid_pc_q, tgt_q;
    logic        taken, consumed, ack;
    logic [31:0] target;

    assign taken        = branch_in & zero_in;
    assign target       = branch_pc4 + (branch_imm << 2);
    assign consumed     = valid_q & ~stall_in;
    assign ack          = imem_ack & req_q;
    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign instr_out    = instr_q;
    assign pc_out       = pc_q;
    assign pc_plus4_out = pc4_q;
    assign valid_out    = valid_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FETCH;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            addr_q       <= RESET_PC;
            instr_q      <= '0;
            pc_q         <= '0;
            pc4_q        <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            tgt_q        <= '0;
        end else begin
            req_q <= 1'b1;
            if (taken) begin
                valid_q      <= 1'b0;
                skid_instr_q <= '0;
                skid_pc_q    <= '0;
                // With nothing in flight the target can be requested directly
                if (ack || !req_q) begin
                    state_q <= FETCH;
                    addr_q  <= target;
                end else begin
                    state_q <= DISCARD;
                    tgt_q   <= target;
                end
            end else begin
                case (state_q)
                    FETCH: begin
                        if (ack && (!valid_q || consumed)) begin
                            instr_q <= imem_rdata;
                            pc_q    <= addr_q;
                            pc4_q   <= addr_q + 32'd4;
                            valid_q <= 1'b1;
                            addr_q  <= addr_q + 32'd4;
                        end else if (ack) begin
                            skid_instr_q <= imem_rdata;
                            skid_pc_q    <= addr_q;
                            state_q      <= HOLD;
                            req_q        <= 1'b0;
                        end else if (consumed) begin
                            valid_q <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (consumed) begin
                            instr_q <= skid_instr_q;
                            pc_q    <= skid_pc_q;
                            pc4_q   <= skid_pc_q + 32'd4;
                            addr_q  <= skid_pc_q + 32'd4;
                            state_q <= FETCH;
                        end else begin
                            req_q <= 1'b0;
                        end
                    end
                    DISCARD: begin
                        if (ack) begin
                            state_q <= FETCH;
                            addr_q  <= tgt_q;
                        end
                    end
                    default: state_q <= FETCH;
                endcase
            end
        end
    end
endmodule
